ps2_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 15 +
 rtl/ps2_sync_filter.sv | 49 ++++
 rtl/ps2_rx.sv | 138 +++++++++++++
 tb/tb_ps2_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receiver.
//   ps2_rx_state_t - deframing FSM states
//   PS2_DATA_BITS  - payload bits per PS/2 frame
package ps2_pkg;

    localparam int unsigned PS2_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_rx_state_t;

endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: 2-FF synchronizer plus glitch filter for the PS/2 clock pin.
//   CLOCK_50 - system clock (rising edge)
//   reset    - asynchronous, active-high reset
//   raw      - raw asynchronous pin
//   level    - filtered level, changes only after FILTER_LEN identical samples
//   fall     - one-cycle strobe on a filtered 1->0 transition
// FILTER_LEN must be at least 2.
module ps2_sync_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic fall
);

    logic [1:0]            sync_q;
    logic [FILTER_LEN-1:0] hist_q;
    logic                  level_q;
    logic                  level_d;

    // Everything resets high (idle bus) so no edge is seen coming out of reset.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_q  <= '1;
            hist_q  <= '1;
            level_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], raw};
            hist_q  <= {hist_q[FILTER_LEN-2:0], sync_q[1]};
            level_q <= level_d;
        end
    end

    always_comb begin
        level_d = level_q;
        if (hist_q == '0) begin
            level_d = 1'b0;
        end else if (hist_q == '1) begin
            level_d = 1'b1;
        end
    end

    assign level = level_q;
    // Combinational so the strobe lands 2 + FILTER_LEN cycles after the pin drops.
    assign fall  = level_q & ~level_d;

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver, deframes 11-bit frames in the CLOCK_50 domain.
//   CLOCK_50 - 50 MHz system clock
//   reset    - asynchronous, active-high reset
//   PS2_CLK  - raw PS/2 clock pin
//   PS2_DAT  - raw PS/2 data pin
//   rx_data  - last good byte, held until the next good byte
//   rx_valid - one-cycle pulse when rx_data updates
//   rx_error - one-cycle pulse on a rejected frame (start/parity/stop or timeout)
//   rx_busy  - high while a frame is in progress
// Optional: define PS2_RX_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES
// cycles without a filtered falling clock edge.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     PS2_CLK,
    input  logic                     PS2_DAT,
    output logic [PS2_DATA_BITS-1:0] rx_data,
    output logic                     rx_valid,
    output logic                     rx_error,
    output logic                     rx_busy
);

    localparam int unsigned CNT_W = $clog2(PS2_DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PS2_DATA_BITS - 1);

    ps2_rx_state_t            state_q;
    logic [CNT_W-1:0]         bit_cnt_q;
    logic [PS2_DATA_BITS-1:0] shift_q;
    logic                     parity_ok_q;
    logic [1:0]               dat_sync_q;
    logic                     dat;
    logic                     fall;
    logic                     unused_clk_filt;
    logic                     timeout_hit;

    ps2_sync_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .raw     (PS2_CLK),
        .level   (unused_clk_filt),
        .fall    (fall)
    );

    // Data only needs synchronizing; it is stable around the filtered clock edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            dat_sync_q <= '1;
        end else begin
            dat_sync_q <= {dat_sync_q[0], PS2_DAT};
        end
    end

    assign dat = dat_sync_q[1];

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q;

    // A fall in the same cycle keeps the frame alive.
    assign timeout_hit = (state_q != IDLE) && !fall && (to_cnt_q == TO_MAX);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else if (fall || (state_q == IDLE) || timeout_hit) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_ok_q <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_error    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            if (fall) begin
                unique case (state_q)
                    IDLE: begin
                        // A high bit on a stray edge is not a start bit; ignore it.
                        if (!dat) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        // LSB arrives first, so shift in from the top.
                        shift_q   <= {dat, shift_q[PS2_DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        // Odd parity: data plus parity bit must hold an odd number of ones.
                        parity_ok_q <= ^{dat, shift_q};
                        state_q     <= STOP;
                    end
                    STOP: begin
                        if (dat && parity_ok_q) begin
                            rx_data  <= shift_q;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_error <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (timeout_hit) begin
                state_q  <= IDLE;
                rx_error <= 1'b1;
            end
        end
    end

    assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed self-checking bench for ps2_rx.
// Define PS2_RX_TIMEOUT_EN for both bench and RTL to exercise the timeout path.
module tb_ps2_rx;

    localparam int FILT = 8;
    localparam int TMO  = 1000;
    localparam int HALF = 100;   // half PS/2 clock period in CLOCK_50 cycles

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_fall_cyc = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    bit both_seen = 1'b0;
    bit long_seen = 1'b0;
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;

    ps2_rx #(
        .FILTER_LEN    (FILT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .PS2_CLK (PS2_CLK),
        .PS2_DAT (PS2_DAT),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_error(rx_error),
        .rx_busy (rx_busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc++;

    always @(negedge CLOCK_50) begin
        if (rx_valid) valid_cnt++;
        if (rx_error) err_cnt++;
        if (rx_valid && rx_error) both_seen = 1'b1;
        if ((rx_valid && prev_v) || (rx_error && prev_e)) long_seen = 1'b1;
        prev_v = rx_valid;
        prev_e = rx_error;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Data changes mid-high phase, then clock low for HALF, then back high.
    task automatic send_bit(input logic b, input bit glitch);
        if (glitch) begin
            wait_cyc(20);
            PS2_CLK = 1'b0;
            wait_cyc(3);
            PS2_CLK = 1'b1;
            wait_cyc(27);
        end else begin
            wait_cyc(HALF / 2);
        end
        PS2_DAT = b;
        wait_cyc(HALF / 2);
        PS2_CLK = 1'b0;
        last_fall_cyc = cyc;
        wait_cyc(HALF);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int glitch_bit);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], i == glitch_bit);
        send_bit(par, 1'b0);
        send_bit(stop, 1'b0);
        PS2_DAT = 1'b1;
        wait_cyc(HALF);
    endtask

    int v0;
    int e0;
    int n;

    initial begin
        reset   = 1'b1;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        wait_cyc(5);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_valid", rx_valid, 1'b0);
        chk("reset_error", rx_error, 1'b0);
        chk("reset_busy", rx_busy, 1'b0);
        reset = 1'b0;
        wait_cyc(50);

        // Single good frame 0x1C (odd parity bit 0).
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        chk("f1c_valid_cnt", valid_cnt - v0, 1);
        chk("f1c_data", rx_data, 8'h1C);
        chk("f1c_err_cnt", err_cnt - e0, 0);
        chk("f1c_busy", rx_busy, 1'b0);

        // Back-to-back 0xF0 (parity 1) then 0x1C.
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        chk("ff0_data", rx_data, 8'hF0);
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        chk("b2b_data", rx_data, 8'h1C);
        chk("b2b_valid_cnt", valid_cnt - v0, 2);
        chk("b2b_err_cnt", err_cnt - e0, 0);

        // 0x29 has three ones so correct parity is 0; send 1 to break it.
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h29, 1'b1, 1'b1, -1);
        chk("par_err_cnt", err_cnt - e0, 1);
        chk("par_valid_cnt", valid_cnt - v0, 0);
        chk("par_data", rx_data, 8'h1C);

        // Good parity, bad stop bit.
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h29, 1'b0, 1'b0, -1);
        chk("stop_err_cnt", err_cnt - e0, 1);
        chk("stop_valid_cnt", valid_cnt - v0, 0);
        chk("stop_data", rx_data, 8'h1C);
        chk("stop_busy", rx_busy, 1'b0);

        // Move rx_data off 0x1C so the glitched frame's result is visible.
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        chk("pre_glitch_data", rx_data, 8'hF0);

        // 3-cycle clock glitch while idle, then mid-frame before data bit 3.
        v0 = valid_cnt; e0 = err_cnt;
        PS2_CLK = 1'b0;
        wait_cyc(3);
        PS2_CLK = 1'b1;
        wait_cyc(50);
        chk("glitch_idle_busy", rx_busy, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 3);
        chk("glitch_valid_cnt", valid_cnt - v0, 1);
        chk("glitch_err_cnt", err_cnt - e0, 0);
        chk("glitch_data", rx_data, 8'h1C);

        // Partial frame: start + 5 data bits of 0x29, then the clock stops.
        e0 = err_cnt;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(((8'h29 >> i) & 8'h01) != 0, 1'b0);
        PS2_DAT = 1'b1;
`ifdef PS2_RX_TIMEOUT_EN
        n = 0;
        while (!rx_error && n < 4 * TMO) begin
            wait_cyc(1);
            n++;
        end
        // pin->fall strobe is 2+FILT cycles, the FSM sees it one edge later, then TMO more.
        chk("timeout_latency", cyc - last_fall_cyc, 3 + FILT + TMO);
        wait_cyc(5);
        chk("timeout_busy", rx_busy, 1'b0);
        chk("timeout_err_cnt", err_cnt - e0, 1);
`else
        wait_cyc(3 * TMO);
        chk("hang_busy", rx_busy, 1'b1);
        chk("hang_err_cnt", err_cnt - e0, 0);
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(50);
`endif
        v0 = valid_cnt;
        send_frame(8'h29, 1'b0, 1'b1, -1);
        chk("after_partial_valid_cnt", valid_cnt - v0, 1);
        chk("after_partial_data", rx_data, 8'h29);

        // Reset after the 4th data bit of 0x5A (parity 1).
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(((8'h5A >> i) & 8'h01) != 0, 1'b0);
        chk("pre_reset_busy", rx_busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("midreset_busy", rx_busy, 1'b0);
        chk("midreset_data", rx_data, 8'h00);
        chk("midreset_valid", rx_valid, 1'b0);
        wait_cyc(3);
        reset = 1'b0;
        PS2_DAT = 1'b1;
        wait_cyc(HALF);
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h5A, 1'b1, 1'b1, -1);
        chk("post_reset_valid_cnt", valid_cnt - v0, 1);
        chk("post_reset_err_cnt", err_cnt - e0, 0);
        chk("post_reset_data", rx_data, 8'h5A);

        chk("valid_error_overlap", both_seen, 1'b0);
        chk("pulse_longer_than_one", long_seen, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
